univ_shift_reg: RTL and testbench

Parametrised universal shift register, the successor to the free-running serial shifter. Provides hold, bidirectional shift, rotate, parallel load and synchronous clear on an N-bit register, selected per cycle by a mode input under a clock enable. A shift counter and a one-cycle done pulse mark when a loaded word has been fully shifted out. Used as the serialiser/deserialiser core for the sandbox serial-link experiments.

---
 rtl/univ_shift_reg.sv | 108 ++++++++++
 tb/tb_univ_shift_reg.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: hold, shift, rotate, load and clear per cycle,
// with a saturating shift counter and a one-cycle done pulse per shifted-out word.
module univ_shift_reg #(
  parameter int N = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [N-1:0]  d,
  input  logic          s_in_msb,
  input  logic          s_in_lsb,
  output logic [N-1:0]  q,
  output logic          s_out_r,
  output logic          s_out_l,
  output logic [CW-1:0] cnt,
  output logic          done
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  logic [N-1:0]  q_r;
  logic [CW-1:0] cnt_r;
  logic          done_r;

  logic [N-1:0]  q_nxt_s;
  logic [CW-1:0] cnt_nxt_s;
  logic          done_nxt_s;
  logic          shift_s;

  // Next-state decode for register, counter and done pulse
  always_comb begin
    q_nxt_s    = q_r;
    cnt_nxt_s  = cnt_r;
    done_nxt_s = 1'b0;
    shift_s    = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_SHR: begin
          q_nxt_s = {s_in_msb, q_r[N-1:1]};
          shift_s = 1'b1;
        end
        MODE_SHL: begin
          q_nxt_s = {q_r[N-2:0], s_in_lsb};
          shift_s = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt_s   = d;
          cnt_nxt_s = {CW{1'b0}};
        end
        MODE_ROR: begin
          q_nxt_s = {q_r[0], q_r[N-1:1]};
          shift_s = 1'b1;
        end
        MODE_ROL: begin
          q_nxt_s = {q_r[N-2:0], q_r[N-1]};
          shift_s = 1'b1;
        end
        MODE_CLR: begin
          q_nxt_s   = {N{1'b0}};
          cnt_nxt_s = {CW{1'b0}};
        end
        default: begin
          q_nxt_s = q_r;
        end
      endcase
    end else begin
      q_nxt_s = q_r;
    end
    // Counter saturates at N so done can only fire on the N-1 -> N step
    if (shift_s && (cnt_r != CW'(N))) begin
      cnt_nxt_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      done_nxt_s = (cnt_r == CW'(N - 1));
    end else begin
      done_nxt_s = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r    <= {N{1'b0}};
      cnt_r  <= {CW{1'b0}};
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      cnt_r  <= cnt_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign q       = q_r;
  assign cnt     = cnt_r;
  assign done    = done_r;
  assign s_out_r = q_r[0];
  assign s_out_l = q_r[N-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed scoreboard bench for univ_shift_reg at N=8, plus N=2 and N=16 done-timing checks.
module tb_univ_shift_reg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_RSVD = 3'b111;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       en8 = 1'b0;
  logic [2:0] mode8 = 3'b000;
  logic [7:0] d8 = 8'h00;
  logic       smsb8 = 1'b0;
  logic       slsb8 = 1'b0;
  logic [7:0] q8;
  logic       sor8, sol8, done8;
  logic [3:0] cnt8;

  logic       en2 = 1'b0;
  logic [2:0] mode2 = 3'b000;
  logic [1:0] d2 = 2'b00;
  logic [1:0] q2;
  logic       sor2, sol2, done2;
  logic [1:0] cnt2;

  logic        en16 = 1'b0;
  logic [2:0]  mode16 = 3'b000;
  logic [15:0] d16 = 16'h0000;
  logic [15:0] q16;
  logic        sor16, sol16, done16;
  logic [4:0]  cnt16;

  univ_shift_reg #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .en(en8), .mode(mode8), .d(d8),
    .s_in_msb(smsb8), .s_in_lsb(slsb8), .q(q8), .s_out_r(sor8),
    .s_out_l(sol8), .cnt(cnt8), .done(done8)
  );

  univ_shift_reg #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .mode(mode2), .d(d2),
    .s_in_msb(1'b0), .s_in_lsb(1'b0), .q(q2), .s_out_r(sor2),
    .s_out_l(sol2), .cnt(cnt2), .done(done2)
  );

  univ_shift_reg #(.N(16)) dut16 (
    .clk(clk), .reset(reset), .en(en16), .mode(mode16), .d(d16),
    .s_in_msb(1'b0), .s_in_lsb(1'b0), .q(q16), .s_out_r(sor16),
    .s_out_l(sol16), .cnt(cnt16), .done(done16)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] cnt;
    logic       done;
  } exp_t;

  exp_t sb[$];
  logic [7:0] mq = 8'h00;
  int         mc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  int         n_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq = 8'h00;
    mc = 0;
  endtask

  // Drive one N=8 operation, predict its result, then compare after the edge
  task automatic step8(input string tag, input logic [2:0] m, input logic e,
                       input logic [7:0] dd, input logic smsb, input logic slsb);
    exp_t x;
    logic rot;
    en8 = e; mode8 = m; d8 = dd; smsb8 = smsb; slsb8 = slsb;
    rot = 1'b0;
    x.done = 1'b0;
    if (e) begin
      if (m == M_SHR)      begin mq = {smsb, mq[7:1]}; rot = 1'b1; end
      else if (m == M_SHL) begin mq = {mq[6:0], slsb}; rot = 1'b1; end
      else if (m == M_ROR) begin mq = {mq[0], mq[7:1]}; rot = 1'b1; end
      else if (m == M_ROL) begin mq = {mq[6:0], mq[7]}; rot = 1'b1; end
      else if (m == M_LOAD) begin mq = dd; mc = 0; end
      else if (m == M_CLR)  begin mq = 8'h00; mc = 0; end
    end
    if (rot && mc < 8) begin
      mc++;
      x.done = (mc == 8);
    end
    x.q = mq;
    x.cnt = 4'(mc);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, "_q"}, 32'(q8), 32'(x.q));
    chk({tag, "_cnt"}, 32'(cnt8), 32'(x.cnt));
    chk({tag, "_done"}, 32'(done8), 32'(x.done));
    chk({tag, "_sor"}, 32'(sor8), 32'(x.q[0]));
    chk({tag, "_sol"}, 32'(sol8), 32'(x.q[7]));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [7:0] ser;
    logic [7:0] fill;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(q8), 32'h0);
    chk("rst_cnt", 32'(cnt8), 32'h0);
    chk("rst_done", 32'(done8), 32'h0);
    reset = 1'b1;

    // Mid-cycle asynchronous reset
    step8("t1_load", M_LOAD, 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("t1_q_a5", 32'(q8), 32'hA5);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("t1_async_q", 32'(q8), 32'h0);
    chk("t1_async_cnt", 32'(cnt8), 32'h0);
    chk("t1_async_done", 32'(done8), 32'h0);
    #2;
    reset = 1'b1;
    step8("t1_hold", M_HOLD, 1'b1, 8'hFF, 1'b1, 1'b1);

    // Load then serialise LSB-first
    step8("t2_load", M_LOAD, 1'b1, 8'hB4, 1'b0, 1'b0);
    ser = 8'hB4;
    for (int i = 0; i < 8; i++) begin
      chk("t2_ser", 32'(sor8), 32'(ser[i]));
      step8("t2_shr", M_SHR, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    chk("t2_q_final", 32'(q8), 32'h00);
    chk("t2_cnt8", 32'(cnt8), 32'h8);
    chk("t2_done8", 32'(done8), 32'h1);
    step8("t2_shr9", M_SHR, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("t2_sat_cnt", 32'(cnt8), 32'h8);
    chk("t2_sat_done", 32'(done8), 32'h0);

    // Rotates
    step8("t3_load", M_LOAD, 1'b1, 8'h81, 1'b0, 1'b0);
    step8("t3_rol", M_ROL, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("t3_q_03", 32'(q8), 32'h03);
    n_done += int'(done8);
    for (int i = 0; i < 2; i++) begin
      step8("t3_ror", M_ROR, 1'b1, 8'h00, 1'b0, 1'b0);
      n_done += int'(done8);
    end
    chk("t3_q_c0", 32'(q8), 32'hC0);
    for (int i = 0; i < 6; i++) begin
      step8("t3_ror6", M_ROR, 1'b1, 8'h00, 1'b0, 1'b0);
      n_done += int'(done8);
    end
    chk("t3_q_03b", 32'(q8), 32'h03);
    chk("t3_done_count", 32'(n_done), 32'h1);

    // Serial fill from the LSB side; reserved mode holds
    step8("t4_clr", M_CLR, 1'b1, 8'h00, 1'b0, 1'b0);
    fill = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      step8("t4_shl", M_SHL, 1'b1, 8'h00, 1'b0, fill[i]);
    end
    chk("t4_q_b2", 32'(q8), 32'hB2);
    chk("t4_sol", 32'(sol8), 32'h1);
    step8("t4_rsvd", M_RSVD, 1'b1, 8'h00, 1'b1, 1'b1);

    // Enable gating
    step8("t5_load", M_LOAD, 1'b1, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step8("t5_en", M_SHR, (i % 2 == 0), 8'h00, 1'b1, 1'b0);
    end
    chk("t5_q_f3", 32'(q8), 32'hF3);
    chk("t5_cnt4", 32'(cnt8), 32'h4);

    // Load priority at cnt=7, then abort by reset mid-word
    step8("t6_load", M_LOAD, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step8("t6_shr7", M_SHR, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("t6_cnt7", 32'(cnt8), 32'h7);
    step8("t6_reload", M_LOAD, 1'b1, 8'h55, 1'b0, 1'b0);
    chk("t6_reload_cnt", 32'(cnt8), 32'h0);
    chk("t6_reload_done", 32'(done8), 32'h0);
    for (int i = 0; i < 5; i++) step8("t6_shr5", M_SHR, 1'b1, 8'h00, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_abort_q", 32'(q8), 32'h0);
    chk("t6_abort_cnt", 32'(cnt8), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step8("t6_post", M_SHR, 1'b1, 8'h00, 1'b0, 1'b0);

    // Other widths: done after exactly N shifts
    en2 = 1'b1; mode2 = M_LOAD; d2 = 2'b10;
    en16 = 1'b1; mode16 = M_LOAD; d16 = 16'hA5C3;
    @(posedge clk);
    #1;
    chk("w2_load", 32'(q2), 32'h2);
    chk("w16_load", 32'(q16), 32'hA5C3);
    mode2 = M_SHR;
    mode16 = M_SHR;
    for (int i = 1; i <= 17; i++) begin
      en2 = (i <= 3);
      @(posedge clk);
      #1;
      chk("w16_done", 32'(done16), 32'(i == 16));
      if (i <= 3) chk("w2_done", 32'(done2), 32'(i == 2));
    end
    chk("w2_cnt", 32'(cnt2), 32'h2);
    chk("w2_q", 32'(q2), 32'h0);
    chk("w16_cnt", 32'(cnt16), 32'h10);
    chk("w16_q", 32'(q16), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
